// File: rtl/shift_ctrl_pkg.sv
// Shared types and default sizing for the shift_ctrl serial framing block.
// Imported by the controller top and its shifter sub-module.
package shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_GAP   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/shift_ctrl_shift_core.sv
// Shared shift register: parallel load, left shift with serial input at the LSB,
// asynchronous clear. The MSB of q is the serial output bit.
module shift_core
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    // Load wins over shift; the controller never asserts both in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], ser_in};
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Frame controller around shift_core: sends a parallel word MSB first (PISO)
// or captures a serial word (SIPO), then idles GAP cycles before the next frame.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int                 CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]         GAP_LAST = 4'(GAP - 1);

    state_t            state;
    state_t            stateNext;
    logic              modeReg;
    logic [CW-1:0]     bitCnt;
    logic [3:0]        gapCnt;
    logic [WIDTH-1:0]  rxData;
    logic              coreLoad;
    logic              coreShift;
    logic              coreSerIn;
    logic [WIDTH-1:0]  coreLoadVal;
    logic [WIDTH-1:0]  coreQ;

    // SIPO frames start from an all-zero register; PISO frames never shift data in.
    assign coreLoadVal = modeReg ? load_data : '0;
    assign coreSerIn   = ~modeReg & ser_in;

    shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (coreLoad),
        .shift   (coreShift),
        .load_val(coreLoadVal),
        .ser_in  (coreSerIn),
        .q       (coreQ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The captured word is written on the last shift edge so it is already
    // visible on rx_data during the DONE cycle; an abort blocks the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modeReg <= 1'b0;
            bitCnt  <= '0;
            gapCnt  <= '0;
            rxData  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                modeReg <= mode;
            end
            if (state == ST_LOAD) begin
                bitCnt <= '0;
            end else if (state == ST_SHIFT) begin
                bitCnt <= bitCnt + CW'(1);
            end
            if (state == ST_DONE) begin
                gapCnt <= '0;
            end else if (state == ST_GAP) begin
                gapCnt <= gapCnt + 4'd1;
            end
            if (state == ST_SHIFT && !abort && bitCnt == BIT_LAST && !modeReg) begin
                rxData <= {coreQ[WIDTH-2:0], ser_in};
            end
        end
    end

    always_comb begin
        stateNext = state;
        shift_en  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        coreLoad  = 1'b0;
        coreShift = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    stateNext = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    stateNext = ST_IDLE;
                end else begin
                    coreLoad  = 1'b1;
                    stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (abort) begin
                    stateNext = ST_IDLE;
                end else begin
                    coreShift = 1'b1;
                    if (bitCnt == BIT_LAST) begin
                        stateNext = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                stateNext = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gapCnt == GAP_LAST) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    assign ser_out  = (state == ST_SHIFT) & modeReg & coreQ[WIDTH-1];
    assign rx_valid = done & ~modeReg;
    assign rx_data  = rxData;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized self-checking bench for shift_ctrl with two instances:
// unit 0 is WIDTH=4/GAP=1, unit 1 is WIDTH=8/GAP=0, checked against a frame-timeline model.
module tb_shift_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  startV, modeV, abortV, serInV;
    logic [3:0]  ldA;
    logic [7:0]  ldB;
    logic [1:0]  serOutV, shiftEnV, busyV, doneV, rxValidV;
    logic [3:0]  rxA;
    logic [7:0]  rxB;
    logic [15:0] expRx [2];
    int          checks   = 0;
    int          failures = 0;

    shift_ctrl #(.WIDTH(4), .GAP(1)) dutA (
        .clk(clk), .rst(rst), .start(startV[0]), .mode(modeV[0]), .abort(abortV[0]),
        .load_data(ldA), .ser_in(serInV[0]), .ser_out(serOutV[0]), .shift_en(shiftEnV[0]),
        .busy(busyV[0]), .done(doneV[0]), .rx_data(rxA), .rx_valid(rxValidV[0])
    );

    shift_ctrl #(.WIDTH(8), .GAP(0)) dutB (
        .clk(clk), .rst(rst), .start(startV[1]), .mode(modeV[1]), .abort(abortV[1]),
        .load_data(ldB), .ser_in(serInV[1]), .ser_out(serOutV[1]), .shift_en(shiftEnV[1]),
        .busy(busyV[1]), .done(doneV[1]), .rx_data(rxB), .rx_valid(rxValidV[1])
    );

    function automatic int widthOf(input int sel);
        return (sel != 0) ? 8 : 4;
    endfunction

    function automatic int gapOf(input int sel);
        return (sel != 0) ? 0 : 1;
    endfunction

    function automatic logic [15:0] b16(input logic b);
        return {15'b0, b};
    endfunction

    function automatic logic [15:0] rxOf(input int sel);
        return (sel != 0) ? {8'b0, rxB} : {12'b0, rxA};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic st, input logic md, input logic ab,
                                 input logic [15:0] ld, input logic si);
        startV[sel] = st;
        modeV[sel]  = md;
        abortV[sel] = ab;
        serInV[sel] = si;
        if (sel != 0) ldB = ld[7:0];
        else          ldA = ld[3:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input int sel, input string tag);
        string u;
        u = $sformatf("u%0d.%s", sel, tag);
        checkOutput({u, ".busy"},    b16(busyV[sel]),    16'd0);
        checkOutput({u, ".done"},    b16(doneV[sel]),    16'd0);
        checkOutput({u, ".rxValid"}, b16(rxValidV[sel]), 16'd0);
        checkOutput({u, ".shiftEn"}, b16(shiftEnV[sel]), 16'd0);
        checkOutput({u, ".serOut"},  b16(serOutV[sel]),  16'd0);
        checkOutput({u, ".rxData"},  rxOf(sel),          16'd0);
    endtask

    // After an abort the unit must be idle next cycle with nothing reported.
    task automatic expectAbort(input int sel);
        string u;
        u = $sformatf("u%0d.abort", sel);
        tick();
        checkOutput({u, ".busy"},    b16(busyV[sel]),    16'd0);
        checkOutput({u, ".done"},    b16(doneV[sel]),    16'd0);
        checkOutput({u, ".rxValid"}, b16(rxValidV[sel]), 16'd0);
        checkOutput({u, ".rxData"},  rxOf(sel),          expRx[sel]);
        applyStimulus(sel, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    // One frame from an IDLE cycle: start at cycle 0, LOAD at 1, SHIFT at 2..w+1,
    // DONE at w+2, then GAP cycles, then IDLE. abortAt: -2 none, -1 in LOAD, k in SHIFT k.
    task automatic runFrame(input int sel, input logic md, input logic [15:0] ld,
                            input logic [15:0] bits, input int abortAt);
        int          w;
        int          g;
        logic [15:0] captured;
        string       u;
        w        = widthOf(sel);
        g        = gapOf(sel);
        captured = '0;
        u        = $sformatf("u%0d", sel);
        checkOutput({u, ".idleBusy"}, b16(busyV[sel]), 16'd0);
        applyStimulus(sel, 1'b1, md, 1'b0, ld, 1'b0);
        tick();
        checkOutput({u, ".loadBusy"},    b16(busyV[sel]),    16'd1);
        checkOutput({u, ".loadShiftEn"}, b16(shiftEnV[sel]), 16'd0);
        applyStimulus(sel, 1'($urandom), 1'($urandom), abortAt == -1, ld, 1'($urandom));
        if (abortAt == -1) begin
            expectAbort(sel);
            return;
        end
        for (int k = 0; k < w; k++) begin
            tick();
            checkOutput($sformatf("%s.shiftEn[%0d]", u, k), b16(shiftEnV[sel]), 16'd1);
            checkOutput($sformatf("%s.serOut[%0d]", u, k), b16(serOutV[sel]),
                        b16(md ? ld[w-1-k] : 1'b0));
            checkOutput($sformatf("%s.earlyDone[%0d]", u, k), b16(doneV[sel]), 16'd0);
            applyStimulus(sel, 1'($urandom), 1'($urandom), abortAt == k, ld, bits[k]);
            if (abortAt == k) begin
                expectAbort(sel);
                return;
            end
            captured = {captured[14:0], bits[k]};
        end
        tick();
        if (!md) expRx[sel] = captured;
        checkOutput({u, ".done"},        b16(doneV[sel]),    16'd1);
        checkOutput({u, ".rxValid"},     b16(rxValidV[sel]), b16(!md));
        checkOutput({u, ".doneSerOut"},  b16(serOutV[sel]),  16'd0);
        checkOutput({u, ".doneShiftEn"}, b16(shiftEnV[sel]), 16'd0);
        checkOutput({u, ".rxData"},      rxOf(sel),          expRx[sel]);
        applyStimulus(sel, 1'b0, 1'($urandom), 1'($urandom), ld, 1'b0);
        for (int i = 0; i < g; i++) begin
            tick();
            checkOutput($sformatf("%s.gapBusy[%0d]", u, i), b16(busyV[sel]), 16'd1);
            checkOutput($sformatf("%s.gapDone[%0d]", u, i), b16(doneV[sel]), 16'd0);
            applyStimulus(sel, 1'b0, 1'($urandom), 1'($urandom), ld, 1'b0);
        end
        tick();
        checkOutput({u, ".endBusy"}, b16(busyV[sel]), 16'd0);
        checkOutput({u, ".endDone"}, b16(doneV[sel]), 16'd0);
        checkOutput({u, ".endRx"},   rxOf(sel),       expRx[sel]);
        applyStimulus(sel, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    // With start held high, frames repeat every w+2 (to done) + g + 1 (to next start) cycles.
    task automatic holdStart(input int sel);
        int period;
        int firstDone;
        string u;
        period    = widthOf(sel) + 3 + gapOf(sel);
        firstDone = widthOf(sel) + 2;
        u         = $sformatf("u%0d.held", sel);
        applyStimulus(sel, 1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0);
        for (int c = 0; c <= 2 * period; c++) begin
            if (c > 0) tick();
            checkOutput($sformatf("%s.busy[%0d]", u, c), b16(busyV[sel]), b16((c % period) != 0));
            checkOutput($sformatf("%s.done[%0d]", u, c), b16(doneV[sel]),
                        b16(c >= firstDone && ((c - firstDone) % period) == 0));
        end
        applyStimulus(sel, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel;
        int w;
        int abortAt;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        expRx[0] = '0;
        expRx[1] = '0;
        tick();
        tick();
        checkAllZero(0, "reset");
        checkAllZero(1, "reset");
        #3 rst = 1'b0;

        $display("[TB] directed PISO, SIPO and abort frames on WIDTH=4");
        runFrame(0, 1'b1, 16'hB, 16'h0, -2);
        runFrame(0, 1'b0, 16'h0, 16'h3, -2);
        checkOutput("u0.sipoWord", rxOf(0), 16'hC);
        runFrame(0, 1'b0, 16'h0, 16'h5, 2);
        checkOutput("u0.abortKeepsRx", rxOf(0), 16'hC);
        runFrame(0, 1'b0, 16'h0, 16'hA, 3);
        runFrame(0, 1'b1, 16'h9, 16'h0, -1);
        checkOutput("u0.rxAfterAborts", rxOf(0), 16'hC);

        $display("[TB] held start and back-to-back frames");
        holdStart(0);
        holdStart(1);
        runFrame(1, 1'b0, 16'h0, 16'hA5, -2);
        runFrame(1, 1'b1, 16'h96, 16'h0, -2);
        runFrame(1, 1'b0, 16'h0, 16'h3C, -2);

        $display("[TB] reset during a frame");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'hD, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'hD, 1'b0);
        tick();
        tick();
        checkOutput("u0.preResetShiftEn", b16(shiftEnV[0]), 16'd1);
        #3 rst = 1'b1;
        #2;
        expRx[0] = '0;
        expRx[1] = '0;
        checkAllZero(0, "midReset");
        checkAllZero(1, "midReset");
        #1 rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        runFrame(0, 1'b1, 16'h6, 16'h0, -2);
        runFrame(0, 1'b0, 16'h0, 16'h9, -2);

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            sel     = int'($urandom_range(0, 1));
            w       = widthOf(sel);
            abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) - 1 : -2;
            runFrame(sel, 1'($urandom), 16'($urandom), 16'($urandom), abortAt);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                tick();
                checkOutput("idleBusy0", b16(busyV[0]), 16'd0);
                checkOutput("idleBusy1", b16(busyV[1]), 16'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
